// File: rtl/cmsdk_tb_cmd_sequencer.sv
// Decodes the MCU stdout byte stream into bench commands and sequences the debug tester.
// Optional inter-byte watchdog for ESC/AUX/DCMD: define CMSDK_TB_CMD_ESC_TIMEOUT_EN.
module cmsdk_tb_cmd_sequencer #(
    parameter int ACK_TIMEOUT = 1024,
    parameter int ESC_TIMEOUT = 4096
) (
    input  logic       CLK,
    input  logic       RESETn,
    input  logic       RX_VALID,
    input  logic [7:0] RX_DATA,
    input  logic       DBG_RUNNING,
    input  logic       DBG_ERR,
    output logic       DEBUG_TESTER_ENABLE,
    output logic [7:0] AUXCTRL,
    output logic [5:0] DBG_CMD,
    output logic       DBG_START,
    output logic       SIMULATIONEND,
    output logic       CMD_ERR,
    output logic       DBG_FAIL,
    output logic       BUSY
);

    typedef enum logic [2:0] {
        ST_IDLE, ST_ESC, ST_AUX, ST_DCMD, ST_DACK, ST_DRUN, ST_END
    } state_t;

    localparam logic [15:0] ACK_LAST = 16'(ACK_TIMEOUT - 1);

    state_t      state_r, state_s;
    logic        en_r, en_s;
    logic [7:0]  aux_r, aux_s;
    logic [5:0]  cmd_r, cmd_s;
    logic        start_r, start_s;
    logic        end_r, end_s;
    logic        err_r, err_s;
    logic        fail_r, fail_s;
    logic        busy_r;
    logic [15:0] ack_cnt_r;
    logic        esc_tmo_s;
    logic        in_cmd_s;

    assign in_cmd_s = (state_r == ST_ESC) || (state_r == ST_AUX) || (state_r == ST_DCMD);

`ifdef CMSDK_TB_CMD_ESC_TIMEOUT_EN
    localparam logic [15:0] ESC_LAST = 16'(ESC_TIMEOUT - 1);
    logic [15:0] esc_cnt_r;

    // Inter-byte watchdog: restarts on every byte and outside the command states
    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            esc_cnt_r <= 16'd0;
        end else if (RX_VALID || !in_cmd_s) begin
            esc_cnt_r <= 16'd0;
        end else begin
            esc_cnt_r <= esc_cnt_r + 16'd1;
        end
    end

    assign esc_tmo_s = in_cmd_s && !RX_VALID && (esc_cnt_r == ESC_LAST);
`else
    // Watchdog not built; the comparison is constant-false for every legal ESC_TIMEOUT
    assign esc_tmo_s = (ESC_TIMEOUT < 0);
`endif

    // Acknowledge wait counter, zero on entry to DACK
    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            ack_cnt_r <= 16'd0;
        end else if (state_r == ST_DACK) begin
            ack_cnt_r <= ack_cnt_r + 16'd1;
        end else begin
            ack_cnt_r <= 16'd0;
        end
    end

    // Next-state and next-output decode
    always_comb begin
        state_s = state_r;
        en_s    = en_r;
        aux_s   = aux_r;
        cmd_s   = cmd_r;
        start_s = 1'b0;
        end_s   = end_r;
        err_s   = 1'b0;
        fail_s  = fail_r;
        case (state_r)
            ST_IDLE: begin
                if (RX_VALID && (RX_DATA == 8'h04)) begin
                    end_s   = 1'b1;
                    state_s = ST_END;
                end else if (RX_VALID && (RX_DATA == 8'h1B)) begin
                    state_s = ST_ESC;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ESC: begin
                if (RX_VALID) begin
                    case (RX_DATA)
                        8'h11: begin en_s = 1'b1; state_s = ST_IDLE; end
                        8'h12: begin en_s = 1'b0; state_s = ST_IDLE; end
                        8'h20: state_s = ST_AUX;
                        8'h13: state_s = ST_DCMD;
                        8'h1B: state_s = ST_ESC;
                        8'h04: begin end_s = 1'b1; state_s = ST_END; end
                        default: begin err_s = 1'b1; state_s = ST_IDLE; end
                    endcase
                end else if (esc_tmo_s) begin
                    err_s   = 1'b1;
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_ESC;
                end
            end
            ST_AUX: begin
                if (RX_VALID) begin
                    aux_s   = RX_DATA;
                    state_s = ST_IDLE;
                end else if (esc_tmo_s) begin
                    err_s   = 1'b1;
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_AUX;
                end
            end
            ST_DCMD: begin
                if (RX_VALID) begin
                    if (!en_r || (RX_DATA[7:6] != 2'b00)) begin
                        err_s   = 1'b1;
                        state_s = ST_IDLE;
                    end else begin
                        cmd_s   = RX_DATA[5:0];
                        start_s = 1'b1;
                        state_s = ST_DACK;
                    end
                end else if (esc_tmo_s) begin
                    err_s   = 1'b1;
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_DCMD;
                end
            end
            ST_DACK: begin
                // End-of-simulation beats a rising ack; a rising ack beats the timeout
                if (RX_VALID && (RX_DATA == 8'h04)) begin
                    end_s   = 1'b1;
                    state_s = ST_END;
                end else if (DBG_RUNNING) begin
                    state_s = ST_DRUN;
                end else if (ack_cnt_r == ACK_LAST) begin
                    err_s   = 1'b1;
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_DACK;
                end
            end
            ST_DRUN: begin
                if (RX_VALID && (RX_DATA == 8'h04)) begin
                    end_s   = 1'b1;
                    state_s = ST_END;
                end else if (!DBG_RUNNING) begin
                    fail_s  = fail_r | DBG_ERR;
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_DRUN;
                end
            end
            ST_END: begin
                state_s = ST_END;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs
    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            state_r <= ST_IDLE;
            en_r    <= 1'b0;
            aux_r   <= 8'h00;
            cmd_r   <= 6'h00;
            start_r <= 1'b0;
            end_r   <= 1'b0;
            err_r   <= 1'b0;
            fail_r  <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            en_r    <= en_s;
            aux_r   <= aux_s;
            cmd_r   <= cmd_s;
            start_r <= start_s;
            end_r   <= end_s;
            err_r   <= err_s;
            fail_r  <= fail_s;
            busy_r  <= (state_s != ST_IDLE);
        end
    end

    assign DEBUG_TESTER_ENABLE = en_r;
    assign AUXCTRL             = aux_r;
    assign DBG_CMD             = cmd_r;
    assign DBG_START           = start_r;
    assign SIMULATIONEND       = end_r;
    assign CMD_ERR             = err_r;
    assign DBG_FAIL            = fail_r;
    assign BUSY                = busy_r;

endmodule

// File: tb/tb_cmsdk_tb_cmd_sequencer.sv
// Directed table-driven bench for cmsdk_tb_cmd_sequencer with hand-written multi-cycle sequences.
module tb_cmsdk_tb_cmd_sequencer;

    localparam int ACK_T = 20;
    localparam int ESC_T = 16;

    logic       CLK = 1'b0;
    logic       RESETn;
    logic       RX_VALID;
    logic [7:0] RX_DATA;
    logic       DBG_RUNNING;
    logic       DBG_ERR;
    logic       DEBUG_TESTER_ENABLE;
    logic [7:0] AUXCTRL;
    logic [5:0] DBG_CMD;
    logic       DBG_START;
    logic       SIMULATIONEND;
    logic       CMD_ERR;
    logic       DBG_FAIL;
    logic       BUSY;

    int checks = 0;
    int errors = 0;

    cmsdk_tb_cmd_sequencer #(.ACK_TIMEOUT(ACK_T), .ESC_TIMEOUT(ESC_T)) dut (
        .CLK(CLK), .RESETn(RESETn), .RX_VALID(RX_VALID), .RX_DATA(RX_DATA),
        .DBG_RUNNING(DBG_RUNNING), .DBG_ERR(DBG_ERR),
        .DEBUG_TESTER_ENABLE(DEBUG_TESTER_ENABLE), .AUXCTRL(AUXCTRL), .DBG_CMD(DBG_CMD),
        .DBG_START(DBG_START), .SIMULATIONEND(SIMULATIONEND), .CMD_ERR(CMD_ERR),
        .DBG_FAIL(DBG_FAIL), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic       run;
        logic       derr;
        logic       en;
        logic [7:0] aux;
        logic [5:0] cmd;
        logic       start;
        logic       send;
        logic       cerr;
        logic       fail;
        logic       busy;
    } vec_t;

    vec_t tbl [25];

    function automatic vec_t mk(input logic v, input logic [7:0] d, input logic run,
                                input logic derr, input logic en, input logic [7:0] aux,
                                input logic [5:0] cmd, input logic start, input logic send,
                                input logic cerr, input logic fail, input logic busy);
        vec_t r;
        r.v = v; r.d = d; r.run = run; r.derr = derr; r.en = en; r.aux = aux; r.cmd = cmd;
        r.start = start; r.send = send; r.cerr = cerr; r.fail = fail; r.busy = busy;
        return r;
    endfunction

    task automatic step(input logic v, input logic [7:0] d, input logic run, input logic de);
        @(negedge CLK);
        RX_VALID = v; RX_DATA = d; DBG_RUNNING = run; DBG_ERR = de;
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic en, input logic [7:0] aux,
                              input logic [5:0] cmd, input logic start, input logic send,
                              input logic cerr, input logic fail, input logic busy);
        chk({tag, " en"}, 32'(DEBUG_TESTER_ENABLE), 32'(en));
        chk({tag, " aux"}, 32'(AUXCTRL), 32'(aux));
        chk({tag, " cmd"}, 32'(DBG_CMD), 32'(cmd));
        chk({tag, " start"}, 32'(DBG_START), 32'(start));
        chk({tag, " simend"}, 32'(SIMULATIONEND), 32'(send));
        chk({tag, " cmd_err"}, 32'(CMD_ERR), 32'(cerr));
        chk({tag, " dbg_fail"}, 32'(DBG_FAIL), 32'(fail));
        chk({tag, " busy"}, 32'(BUSY), 32'(busy));
    endtask

    // DBG_START and CMD_ERR must never coincide
    always @(negedge CLK) begin
        if (DBG_START || CMD_ERR) begin
            checks++;
            if (DBG_START && CMD_ERR) begin
                errors++;
                $display("FAIL start_err_exclusive: start=%0b cmd_err=%0b required not both", DBG_START, CMD_ERR);
            end
        end
    end

    initial begin
        int   found;
        int   starts;
        int   lowbusy;
        logic en_exp;
        logic exp_cerr;
        logic exp_busy;

        //            v  d      run derr en aux    cmd    st end cerr fail busy
        tbl[0]  = mk(1, 8'h1B, 0, 0, 0, 8'h00, 6'h00, 0, 0, 0, 0, 1);
        tbl[1]  = mk(1, 8'h11, 0, 0, 1, 8'h00, 6'h00, 0, 0, 0, 0, 0);
        tbl[2]  = mk(0, 8'h00, 0, 0, 1, 8'h00, 6'h00, 0, 0, 0, 0, 0);
        tbl[3]  = mk(1, 8'h1B, 0, 0, 1, 8'h00, 6'h00, 0, 0, 0, 0, 1);
        tbl[4]  = mk(1, 8'h12, 0, 0, 0, 8'h00, 6'h00, 0, 0, 0, 0, 0);
        tbl[5]  = mk(1, 8'h1B, 0, 0, 0, 8'h00, 6'h00, 0, 0, 0, 0, 1);
        tbl[6]  = mk(1, 8'h13, 0, 0, 0, 8'h00, 6'h00, 0, 0, 0, 0, 1);
        tbl[7]  = mk(1, 8'h05, 0, 0, 0, 8'h00, 6'h00, 0, 0, 1, 0, 0);
        tbl[8]  = mk(0, 8'h00, 0, 0, 0, 8'h00, 6'h00, 0, 0, 0, 0, 0);
        tbl[9]  = mk(1, 8'h41, 0, 0, 0, 8'h00, 6'h00, 0, 0, 0, 0, 0);
        tbl[10] = mk(1, 8'h1B, 0, 0, 0, 8'h00, 6'h00, 0, 0, 0, 0, 1);
        tbl[11] = mk(1, 8'h1B, 0, 0, 0, 8'h00, 6'h00, 0, 0, 0, 0, 1);
        tbl[12] = mk(1, 8'h7F, 0, 0, 0, 8'h00, 6'h00, 0, 0, 1, 0, 0);
        tbl[13] = mk(1, 8'h1B, 0, 0, 0, 8'h00, 6'h00, 0, 0, 0, 0, 1);
        tbl[14] = mk(1, 8'h20, 0, 0, 0, 8'h00, 6'h00, 0, 0, 0, 0, 1);
        tbl[15] = mk(1, 8'h04, 0, 0, 0, 8'h04, 6'h00, 0, 0, 0, 0, 0);
        tbl[16] = mk(1, 8'h1B, 0, 0, 0, 8'h04, 6'h00, 0, 0, 0, 0, 1);
        tbl[17] = mk(1, 8'h20, 0, 0, 0, 8'h04, 6'h00, 0, 0, 0, 0, 1);
        tbl[18] = mk(1, 8'h1B, 0, 0, 0, 8'h1B, 6'h00, 0, 0, 0, 0, 0);
        tbl[19] = mk(1, 8'h1B, 0, 0, 0, 8'h1B, 6'h00, 0, 0, 0, 0, 1);
        tbl[20] = mk(1, 8'h11, 0, 0, 1, 8'h1B, 6'h00, 0, 0, 0, 0, 0);
        tbl[21] = mk(1, 8'h1B, 0, 0, 1, 8'h1B, 6'h00, 0, 0, 0, 0, 1);
        tbl[22] = mk(1, 8'h13, 0, 0, 1, 8'h1B, 6'h00, 0, 0, 0, 0, 1);
        tbl[23] = mk(1, 8'hC5, 0, 0, 1, 8'h1B, 6'h00, 0, 0, 1, 0, 0);
        tbl[24] = mk(0, 8'h00, 1, 1, 1, 8'h1B, 6'h00, 0, 0, 0, 0, 0);

        RESETn = 1'b0; RX_VALID = 1'b0; RX_DATA = 8'h00; DBG_RUNNING = 1'b0; DBG_ERR = 1'b0;
        step(1'b1, 8'h04, 1'b1, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        check_outs("reset", 0, 8'h00, 6'h00, 0, 0, 0, 0, 0);
        RESETn = 1'b1;

        for (int i = 0; i < 25; i++) begin
            step(tbl[i].v, tbl[i].d, tbl[i].run, tbl[i].derr);
            check_outs($sformatf("row%0d", i), tbl[i].en, tbl[i].aux, tbl[i].cmd, tbl[i].start,
                       tbl[i].send, tbl[i].cerr, tbl[i].fail, tbl[i].busy);
        end

        // Ack timeout coinciding with DBG_RUNNING rising: DRUN wins
        step(1'b1, 8'h1B, 1'b0, 1'b0);
        step(1'b1, 8'h13, 1'b0, 1'b0);
        step(1'b1, 8'h03, 1'b0, 1'b0);
        check_outs("d_start", 1, 8'h1B, 6'h03, 1, 0, 0, 0, 1);
        for (int k = 1; k < ACK_T; k++) begin
            step(1'b0, 8'h00, 1'b0, 1'b0);
            chk("d_wait_cmd_err", 32'(CMD_ERR), 32'd0);
            chk("d_wait_busy", 32'(BUSY), 32'd1);
        end
        step(1'b0, 8'h00, 1'b1, 1'b0);
        check_outs("d_tie", 1, 8'h1B, 6'h03, 0, 0, 0, 0, 1);
        step(1'b0, 8'h00, 1'b1, 1'b1);
        check_outs("d_run", 1, 8'h1B, 6'h03, 0, 0, 0, 0, 1);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        check_outs("d_done", 1, 8'h1B, 6'h03, 0, 0, 0, 0, 0);

        // Full debug command with error reported at the fall
        step(1'b1, 8'h1B, 1'b0, 1'b0);
        step(1'b1, 8'h13, 1'b0, 1'b0);
        step(1'b1, 8'h05, 1'b0, 1'b0);
        check_outs("a_start", 1, 8'h1B, 6'h05, 1, 0, 0, 0, 1);
        starts = 1;
        lowbusy = 0;
        for (int k = 1; k < 10; k++) begin
            step(1'b0, 8'h00, 1'b0, 1'b0);
            starts += int'(DBG_START);
            lowbusy += int'(!BUSY);
        end
        for (int k = 0; k < 50; k++) begin
            step(1'b0, 8'h41, 1'b1, 1'b0);
            starts += int'(DBG_START);
            lowbusy += int'(!BUSY);
        end
        step(1'b0, 8'h00, 1'b0, 1'b1);
        check_outs("a_done", 1, 8'h1B, 6'h05, 0, 0, 0, 1, 0);
        chk("a_start_pulses", 32'(starts), 32'd1);
        chk("a_busy_gaps", 32'(lowbusy), 32'd0);

        // No acknowledge: CMD_ERR exactly ACK_T cycles after DBG_START
        step(1'b1, 8'h1B, 1'b0, 1'b0);
        step(1'b1, 8'h13, 1'b0, 1'b0);
        step(1'b1, 8'h01, 1'b0, 1'b0);
        check_outs("b_start", 1, 8'h1B, 6'h01, 1, 0, 0, 1, 1);
        found = 0;
        for (int k = 1; k <= 2 * ACK_T; k++) begin
            step(1'b0, 8'h00, 1'b0, 1'b0);
            if (CMD_ERR && (found == 0)) found = k;
            if (found != 0) break;
        end
        chk("b_ack_timeout_cycles", 32'(found), 32'(ACK_T));
        check_outs("b_err", 1, 8'h1B, 6'h01, 0, 0, 1, 1, 0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        check_outs("b_idle", 1, 8'h1B, 6'h01, 0, 0, 0, 1, 0);

        // 0x04 coinciding with DBG_RUNNING rising in DACK: END wins, then terminal
        step(1'b1, 8'h1B, 1'b0, 1'b0);
        step(1'b1, 8'h13, 1'b0, 1'b0);
        step(1'b1, 8'h02, 1'b0, 1'b0);
        step(1'b1, 8'h04, 1'b1, 1'b0);
        check_outs("c_end", 1, 8'h1B, 6'h02, 0, 1, 0, 1, 1);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b1, 8'h1B, 1'b0, 1'b0);
        step(1'b1, 8'h12, 1'b0, 1'b0);
        check_outs("c_terminal", 1, 8'h1B, 6'h02, 0, 1, 0, 1, 1);

        RESETn = 1'b0;
        step(1'b1, 8'h1B, 1'b1, 1'b1);
        check_outs("reset2", 0, 8'h00, 6'h00, 0, 0, 0, 0, 0);
        RESETn = 1'b1;

        // ESC waits forever in the default build; times out when the watchdog is built
        step(1'b1, 8'h1B, 1'b0, 1'b0);
        chk("e_busy0", 32'(BUSY), 32'd1);
        for (int k = 1; k <= 20; k++) begin
            step(1'b0, 8'h00, 1'b0, 1'b0);
`ifdef CMSDK_TB_CMD_ESC_TIMEOUT_EN
            exp_cerr = (k == ESC_T);
            exp_busy = (k < ESC_T);
`else
            exp_cerr = 1'b0;
            exp_busy = 1'b1;
`endif
            chk($sformatf("e_cmd_err%0d", k), 32'(CMD_ERR), 32'(exp_cerr));
            chk($sformatf("e_busy%0d", k), 32'(BUSY), 32'(exp_busy));
        end
`ifdef CMSDK_TB_CMD_ESC_TIMEOUT_EN
        en_exp = 1'b0;
`else
        en_exp = 1'b1;
`endif
        step(1'b1, 8'h11, 1'b0, 1'b0);
        check_outs("e_after", en_exp, 8'h00, 6'h00, 0, 0, 0, 0, 0);

        // AUX accepts 0x04 as data; plain 0x04 ends simulation; END ignores later commands
        step(1'b1, 8'h1B, 1'b0, 1'b0);
        step(1'b1, 8'h20, 1'b0, 1'b0);
        step(1'b1, 8'h04, 1'b0, 1'b0);
        check_outs("f_aux", en_exp, 8'h04, 6'h00, 0, 0, 0, 0, 0);
        step(1'b1, 8'h04, 1'b0, 1'b0);
        check_outs("f_end", en_exp, 8'h04, 6'h00, 0, 1, 0, 0, 1);
        step(1'b1, 8'h1B, 1'b0, 1'b0);
        step(1'b1, en_exp ? 8'h12 : 8'h11, 1'b0, 1'b0);
        check_outs("f_ignored", en_exp, 8'h04, 6'h00, 0, 1, 0, 0, 1);

        // Reset in the middle of a sequence issues no pulse
        RESETn = 1'b0;
        step(1'b0, 8'h00, 1'b0, 1'b0);
        RESETn = 1'b1;
        step(1'b1, 8'h1B, 1'b0, 1'b0);
        chk("g_busy", 32'(BUSY), 32'd1);
        RESETn = 1'b0;
        step(1'b1, 8'h7F, 1'b0, 1'b0);
        check_outs("g_reset", 0, 8'h00, 6'h00, 0, 0, 0, 0, 0);
        RESETn = 1'b1;
        step(1'b0, 8'h00, 1'b0, 1'b0);
        check_outs("g_after", 0, 8'h00, 6'h00, 0, 0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cmsdk_tb_cmd_sequencer.md
Name: cmsdk_tb_cmd_sequencer

Overview:
Testbench-side controller that decodes the MCU's stdout UART byte stream into control commands. It recognises ESC-prefixed command sequences and sequences the debug tester through a start/running/done handshake. It drives the debug-tester enable, the AUXCTRL byte and the end-of-simulation flag. It sits between the UART receiver byte output and the debug tester / bench control signals at the top of the MCU testbench.

Parameters:
ACK_TIMEOUT, 1024, cycles to wait for DBG_RUNNING to rise after DBG_START before aborting; legal range 2..65535.
ESC_TIMEOUT, 4096, cycles allowed between ESC and its command byte; used only when the optional feature is compiled in.

Ports:
CLK  input  1  testbench clock (same as PCLK)
RESETn  input  1  synchronous active-low reset
RX_VALID  input  1  one-cycle strobe, RX_DATA holds a received byte
RX_DATA  input  8  received UART byte
DBG_RUNNING  input  1  debug tester busy, high while a debug command executes
DBG_ERR  input  1  debug tester error, sampled when DBG_RUNNING falls
DEBUG_TESTER_ENABLE  output  1  connects the debug tester to GPIO P0
AUXCTRL  output  8  general-purpose bench control byte
DBG_CMD  output  6  debug tester command code
DBG_START  output  1  one-cycle pulse launching DBG_CMD
SIMULATIONEND  output  1  sticky end-of-simulation flag
CMD_ERR  output  1  one-cycle pulse on a malformed, illegal or timed-out command
DBG_FAIL  output  1  sticky: some debug command reported DBG_ERR=1
BUSY  output  1  high whenever state is not IDLE

Behaviour:
- Interface: one clock, CLK. RESETn is synchronous and active-low: all state is cleared on the first rising CLK edge with RESETn=0.
- Reset values: state=IDLE, every output 0, all counters 0. Reset mid-operation aborts any sequence without issuing a pulse.
- All outputs are registered. Each response appears on the cycle after the RX_VALID or input edge that causes it.
- States: IDLE, ESC, AUX, DCMD, DACK, DRUN, END.
- IDLE:
  - 0x04 -> SIMULATIONEND=1, go to END.
  - 0x1B -> ESC.
  - Any other byte is ignored (normal printable output).
- ESC, on the next byte:
  - 0x11 -> DEBUG_TESTER_ENABLE=1, IDLE.
  - 0x12 -> DEBUG_TESTER_ENABLE=0, IDLE.
  - 0x20 -> AUX.
  - 0x13 -> DCMD.
  - 0x1B -> stay in ESC (restart the sequence).
  - 0x04 -> SIMULATIONEND=1, END.
  - Any other byte -> CMD_ERR pulse, IDLE.
- AUX: the next byte loads AUXCTRL, then IDLE. Any value is accepted, including 0x04 and 0x1B.
- DCMD, on the next byte:
  - If DEBUG_TESTER_ENABLE=0 -> CMD_ERR pulse, IDLE.
  - Otherwise DBG_CMD<=byte[5:0], DBG_START=1 for exactly one cycle, go to DACK.
  - byte[7:6] must be 00; any other value -> CMD_ERR pulse, IDLE, no start.
- DACK: a 16-bit counter starts from 0.
  - DBG_RUNNING=1 -> DRUN.
  - Counter reaches ACK_TIMEOUT-1 with DBG_RUNNING still 0 -> CMD_ERR pulse, IDLE.
- DRUN: on DBG_RUNNING=0, DBG_FAIL<=DBG_FAIL|DBG_ERR, then IDLE. There is no timeout in DRUN.
- DBG_CMD holds its value until the next accepted command.
- While in DACK or DRUN, received bytes are ignored, except 0x04, which sets SIMULATIONEND and goes to END (the debug wait is abandoned).
- END: terminal; all inputs ignored until reset. DEBUG_TESTER_ENABLE and AUXCTRL keep their values.
- Simultaneous events:
  - In DACK, if RX_VALID with 0x04 coincides with DBG_RUNNING rising, END wins.
  - In DACK, if the timeout coincides with DBG_RUNNING=1, DRUN wins.
- CMD_ERR and DBG_START are never asserted in the same cycle.

Optional Feature:
CMSDK_TB_CMD_ESC_TIMEOUT_EN:
- Defined: a counter runs while in ESC, AUX or DCMD and restarts on every accepted byte. Reaching ESC_TIMEOUT-1 without a byte -> CMD_ERR pulse, IDLE.
- Undefined: these states wait indefinitely, the counter is not built, and ESC_TIMEOUT is unused.

Test Plan:
- Bytes 0x1B,0x11 then 0x1B,0x12 -> DEBUG_TESTER_ENABLE goes 1 one cycle after the 0x11 strobe, then 0 one cycle after the 0x12 strobe; CMD_ERR stays 0.
- 0x1B,0x11 then 0x1B,0x13,0x05; tester raises DBG_RUNNING 10 cycles later, drops it 50 cycles later with DBG_ERR=1 -> single DBG_START pulse, DBG_CMD=0x05, DBG_FAIL=1 after the fall, BUSY low afterwards.
- 0x1B,0x13,0x05 with DEBUG_TESTER_ENABLE=0 -> CMD_ERR pulse, no DBG_START.
- Enabled, then 0x1B,0x13,0x01 with no DBG_RUNNING response -> CMD_ERR exactly ACK_TIMEOUT cycles after DBG_START, state back to IDLE.
- 0x1B,0x20,0x04 -> AUXCTRL=0x04 and SIMULATIONEND stays 0; a following plain 0x04 -> SIMULATIONEND=1; any later 0x1B,0x11 has no effect.
- With the macro defined and ESC_TIMEOUT=16: send 0x1B and wait 20 cycles -> CMD_ERR pulse at cycle 16, and a following 0x11 byte is ignored.
